// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : VGA raster timing generator. Divides clk down to a pixel-enable,
//            runs the horizontal/vertical counters, decodes the visible
//            window and sync windows, and registers blanked colour plus
//            sync so that all three leave the block with the same latency.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] rgb_in,
    output logic        p_tick,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        video_on,
    output logic        frame_tick,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb_out
);

    localparam int c_H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int c_V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] c_H_LAST     = 10'(c_H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST     = 10'(c_V_TOTAL - 1);
    localparam logic [9:0] c_H_VISIBLE  = 10'(H_DISPLAY);
    localparam logic [9:0] c_V_VISIBLE  = 10'(V_DISPLAY);
    localparam logic [9:0] c_HS_FIRST   = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] c_HS_LAST    = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] c_VS_FIRST   = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] c_VS_LAST    = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    // Frame tick sits one line into the vertical blanking interval.
    localparam logic [9:0] c_FRAME_LINE = 10'(V_DISPLAY + 1);

    logic [c_DIV_W-1:0] r_div;
    logic [9:0]         r_h_count;
    logic [9:0]         r_v_count;
    logic               r_hsync;
    logic               r_vsync;
    logic [11:0]        r_rgb;

    logic               w_p_tick;
    logic               w_video_on;
    logic               w_hsync_raw;
    logic               w_vsync_raw;
    logic               w_frame_tick;

    // Pixel-clock divider: free-running 0..CLK_DIV-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div <= '0;
        end else if (w_p_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Raster counters advance once per pixel; the vertical count steps on
    // horizontal wrap, so the (last,last) position rolls to (0,0) in one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_h_count <= '0;
            r_v_count <= '0;
        end else if (w_p_tick) begin
            if (r_h_count == c_H_LAST) begin
                r_h_count <= '0;
                if (r_v_count == c_V_LAST) begin
                    r_v_count <= '0;
                end else begin
                    r_v_count <= r_v_count + 10'd1;
                end
            end else begin
                r_h_count <= r_h_count + 10'd1;
            end
        end
    end

    // Decode of the current counter state (no dependence on rgb_in).
    always_comb begin
        w_p_tick     = 1'b0;
        w_video_on   = 1'b0;
        w_hsync_raw  = 1'b1;
        w_vsync_raw  = 1'b1;
        w_frame_tick = 1'b0;

        w_p_tick     = (r_div == c_DIV_LAST);
        w_video_on   = (r_h_count < c_H_VISIBLE) && (r_v_count < c_V_VISIBLE);
        w_hsync_raw  = !((r_h_count >= c_HS_FIRST) && (r_h_count <= c_HS_LAST));
        w_vsync_raw  = !((r_v_count >= c_VS_FIRST) && (r_v_count <= c_VS_LAST));
        w_frame_tick = w_p_tick && (r_h_count == 10'd0) && (r_v_count == c_FRAME_LINE);
    end

    // Pin stage: colour and syncs are loaded together on each pixel edge so
    // the DAC sees them with identical one-pixel latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_rgb   <= 12'h000;
        end else if (w_p_tick) begin
            r_hsync <= w_hsync_raw;
            r_vsync <= w_vsync_raw;
            r_rgb   <= w_video_on ? rgb_in : 12'h000;
        end
    end

    assign p_tick     = w_p_tick;
    assign pix_x      = r_h_count;
    assign pix_y      = r_v_count;
    assign video_on   = w_video_on;
    assign frame_tick = w_frame_tick;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign rgb_out    = r_rgb;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Self-checking bench for vga_timing_gen. Three instances: a small
//            raster at CLK_DIV=4 (A), the same raster at CLK_DIV=2 (B) and the
//            default 640x480 timing (C). Every cycle all three are compared
//            against an arithmetic model driven by the cycle count since the
//            last reset edge; a vector table and directed sequences cover the
//            window boundaries, line/frame counts and reset behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    typedef struct packed {
        logic        p_tick;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        video_on;
        logic        frame_tick;
        logic        hsync;
        logic        vsync;
        logic [11:0] rgb;
    } obs_t;

    typedef struct {
        int   x;
        int   y;
        logic vid;
        logic ft;
        logic hs;
        logic vs;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] rgb_in = 12'h000;
    logic        rgb_fixed = 1'b0;

    logic a_pt, a_vid, a_ft, a_hs, a_vs;
    logic b_pt, b_vid, b_ft, b_hs, b_vs;
    logic c_pt, c_vid, c_ft, c_hs, c_vs;
    logic [9:0]  a_x, a_y, b_x, b_y, c_x, c_y;
    logic [11:0] a_rgb, b_rgb, c_rgb;

    int checks = 0;
    int errors = 0;

    // Cycle history since the last reset edge, used by the reference model.
    int          cyc = 0;
    logic        valid = 1'b0;
    logic [11:0] hist [0:65535];

    vga_timing_gen #(.H_DISPLAY(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
                     .V_DISPLAY(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
                     .CLK_DIV(4)) dut_a (
        .clk(clk), .reset(reset), .rgb_in(rgb_in), .p_tick(a_pt),
        .pix_x(a_x), .pix_y(a_y), .video_on(a_vid), .frame_tick(a_ft),
        .hsync(a_hs), .vsync(a_vs), .rgb_out(a_rgb));

    vga_timing_gen #(.H_DISPLAY(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
                     .V_DISPLAY(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
                     .CLK_DIV(2)) dut_b (
        .clk(clk), .reset(reset), .rgb_in(rgb_in), .p_tick(b_pt),
        .pix_x(b_x), .pix_y(b_y), .video_on(b_vid), .frame_tick(b_ft),
        .hsync(b_hs), .vsync(b_vs), .rgb_out(b_rgb));

    vga_timing_gen dut_c (
        .clk(clk), .reset(reset), .rgb_in(rgb_in), .p_tick(c_pt),
        .pix_x(c_x), .pix_y(c_y), .video_on(c_vid), .frame_tick(c_ft),
        .hsync(c_hs), .vsync(c_vs), .rgb_out(c_rgb));

    always #5 clk = ~clk;

    // Record rgb_in as sampled at each edge, indexed by cycle since reset.
    always @(posedge clk) begin
        if (reset) begin
            cyc   <= 0;
            valid <= 1'b1;
        end else if (valid) begin
            hist[cyc] <= rgb_in;
            cyc       <= cyc + 1;
        end
    end

    // Expected outputs at cycle c after reset, from pixel arithmetic.
    function automatic obs_t model(int hd, int hf, int hs, int hb,
                                   int vd, int vf, int vs, int vb, int dv, int c);
        obs_t m;
        int ht = hd + hf + hs + hb;
        int vt = vd + vf + vs + vb;
        int n  = c / dv;
        int h  = n % ht;
        int v  = (n / ht) % vt;
        int ph, pv;
        m.p_tick     = ((c % dv) == dv - 1);
        m.x          = 10'(h);
        m.y          = 10'(v);
        m.video_on   = (h < hd) && (v < vd);
        m.frame_tick = m.p_tick && (h == 0) && (v == vd + 1);
        if (n == 0) begin
            m.hsync = 1'b1;
            m.vsync = 1'b1;
            m.rgb   = 12'h000;
        end else begin
            ph      = (n - 1) % ht;
            pv      = ((n - 1) / ht) % vt;
            m.hsync = !((ph >= hd + hf) && (ph < hd + hf + hs));
            m.vsync = !((pv >= vd + vf) && (pv < vd + vf + vs));
            m.rgb   = ((ph < hd) && (pv < vd)) ? hist[n * dv - 1] : 12'h000;
        end
        return m;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to the next negedge, compare every instance, drive new colour.
    task automatic tick();
        obs_t oa, ob, oc;
        @(negedge clk);
        if (valid) begin
            oa = {a_pt, a_x, a_y, a_vid, a_ft, a_hs, a_vs, a_rgb};
            ob = {b_pt, b_x, b_y, b_vid, b_ft, b_hs, b_vs, b_rgb};
            oc = {c_pt, c_x, c_y, c_vid, c_ft, c_hs, c_vs, c_rgb};
            check("model_a", 64'(oa), 64'(model(16, 2, 3, 3, 8, 2, 2, 2, 4, cyc)));
            check("model_b", 64'(ob), 64'(model(16, 2, 3, 3, 8, 2, 2, 2, 2, cyc)));
            check("model_c", 64'(oc), 64'(model(640, 16, 96, 48, 480, 10, 2, 33, 4, cyc)));
        end
        rgb_in = rgb_fixed ? 12'hfff : 12'($urandom);
    endtask

    task automatic wait_pix(int x, int y);
        int n = 0;
        while (!(a_pt && int'(a_x) == x && int'(a_y) == y) && n < 4000) begin
            tick();
            n++;
        end
        check("wait_pix_timeout", 64'(n < 4000), 64'(1));
    endtask

    // Called at the negedge right after a reset edge.
    task automatic check_release();
        for (int i = 0; i < 6; i++) begin
            check("rel_a_ptick", 64'(a_pt), 64'(i == 3));
            check("rel_a_pix_x", 64'(a_x), 64'((i >= 4) ? 1 : 0));
            check("rel_a_pix_y", 64'(a_y), 64'(0));
            check("rel_b_ptick", 64'(b_pt), 64'(i % 2 == 1));
            tick();
        end
    endtask

    vec_t tbl [14];

    initial begin
        int pt, hl, fx, lines, ft, fty, ftx, vl, fvs, rgbn, bad, bft, bpt, y0, n;

        tbl[0]  = '{0,  0,  1'b1, 1'b0, 1'b1, 1'b1};
        tbl[1]  = '{17, 3,  1'b0, 1'b0, 1'b1, 1'b1};
        tbl[2]  = '{18, 3,  1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{20, 3,  1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{21, 3,  1'b0, 1'b0, 1'b1, 1'b1};
        tbl[5]  = '{15, 7,  1'b1, 1'b0, 1'b1, 1'b1};
        tbl[6]  = '{16, 7,  1'b0, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{23, 8,  1'b0, 1'b0, 1'b1, 1'b1};
        tbl[8]  = '{0,  9,  1'b0, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{5,  10, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{19, 11, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{23, 11, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{3,  12, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[13] = '{0,  0,  1'b1, 1'b0, 1'b1, 1'b1};

        // Reset state and first pixel after release.
        reset = 1'b1;
        repeat (3) tick();
        check("rst_ptick", 64'(a_pt), 64'(0));
        check("rst_frame_tick", 64'(a_ft), 64'(0));
        check("rst_hsync", 64'(a_hs), 64'(1));
        check("rst_vsync", 64'(a_vs), 64'(1));
        check("rst_rgb", 64'(a_rgb), 64'(0));
        reset = 1'b0;
        check_release();

        // Window boundaries; syncs observed one pixel after each position.
        for (int i = 0; i < 14; i++) begin
            wait_pix(tbl[i].x, tbl[i].y);
            check($sformatf("vec%0d_video_on", i), 64'(a_vid), 64'(tbl[i].vid));
            check($sformatf("vec%0d_frame_tick", i), 64'(a_ft), 64'(tbl[i].ft));
            tick();
            check($sformatf("vec%0d_hsync", i), 64'(a_hs), 64'(tbl[i].hs));
            check($sformatf("vec%0d_vsync", i), 64'(a_vs), 64'(tbl[i].vs));
        end

        // One line on the small raster.
        wait_pix(0, 2);
        pt = 0; hl = 0; fx = -1;
        for (int i = 0; i < 96; i++) begin
            if (a_pt) begin
                pt++;
                if (!a_hs) begin
                    hl++;
                    if (fx < 0) fx = int'(a_x);
                end
            end
            tick();
        end
        check("lineA_pticks", 64'(pt), 64'(24));
        check("lineA_hsync_low", 64'(hl), 64'(3));
        check("lineA_hsync_first", 64'(fx), 64'(19));
        check("lineA_next_xy", 64'({a_x, a_y}), 64'({10'd0, 10'd3}));

        // One line on the default timing.
        n = 0;
        while (!(c_pt && c_x == 10'd0) && n < 3300) begin
            tick();
            n++;
        end
        check("lineC_wait_timeout", 64'(n < 3300), 64'(1));
        y0 = int'(c_y);
        pt = 0; hl = 0; fx = -1;
        for (int i = 0; i < 3200; i++) begin
            if (c_pt) begin
                pt++;
                if (!c_hs) begin
                    hl++;
                    if (fx < 0) fx = int'(c_x);
                end
            end
            tick();
        end
        check("lineC_pticks", 64'(pt), 64'(800));
        check("lineC_hsync_low", 64'(hl), 64'(96));
        check("lineC_hsync_first", 64'(fx), 64'(657));
        check("lineC_y_step", 64'(c_y), 64'((y0 + 1) % 525));

        // One full frame with constant white input.
        rgb_fixed = 1'b1;
        rgb_in    = 12'hfff;
        wait_pix(0, 0);
        pt = 0; lines = 0; ft = 0; fty = -1; ftx = -1; vl = 0; fvs = -1;
        rgbn = 0; bad = 0; bft = 0; bpt = 0;
        for (int i = 0; i < 1344; i++) begin
            if (a_ft) begin
                ft++;
                fty = int'(a_y);
                ftx = int'(a_x);
            end
            if (b_ft) bft++;
            if (b_pt) bpt++;
            if (a_pt) begin
                pt++;
                if (a_x == 10'd0) lines++;
                if (!a_vs) begin
                    vl++;
                    if (fvs < 0) fvs = int'(a_y) * 1000 + int'(a_x);
                end
                if (a_rgb == 12'hfff) rgbn++;
                else if (a_rgb != 12'h000) bad++;
            end
            tick();
        end
        rgb_fixed = 1'b0;
        check("frame_pticks", 64'(pt), 64'(336));
        check("frame_lines", 64'(lines), 64'(14));
        check("frame_tick_count", 64'(ft), 64'(1));
        check("frame_tick_pos", 64'({ftx, fty}), 64'({32'd0, 32'd9}));
        check("frame_vsync_low", 64'(vl), 64'(48));
        check("frame_vsync_first", 64'(fvs), 64'(10001));
        check("frame_rgb_white", 64'(rgbn), 64'(128));
        check("frame_rgb_other", 64'(bad), 64'(0));
        check("frame_wrap_xy", 64'({a_pt, a_x, a_y}), 64'({1'b1, 10'd0, 10'd0}));
        check("div2_frame_ticks", 64'(bft), 64'(2));
        check("div2_pticks", 64'(bpt), 64'(672));

        // Reset pulse mid-frame.
        wait_pix(10, 5);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("mid_rst_xy", 64'({a_x, a_y}), 64'(0));
        check("mid_rst_ptick", 64'(a_pt), 64'(0));
        check("mid_rst_syncs", 64'({a_hs, a_vs}), 64'(2'b11));
        check("mid_rst_rgb", 64'(a_rgb), 64'(0));
        reset = 1'b0;
        check_release();
        repeat (200) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
